pipe_control: RTL and testbench

- Registered ID-stage control unit for the 5-stage MIPS pipeline.
- Decodes op/funct into a control word and latches it as the ID/EX control register.
- Resolves BEQ/BNE/J/JAL/JR in ID.
- Detects load-use and branch-operand hazards itself, with no external hazard input. It generates stall and flush.
- Sequences program termination: drains the pipeline, then halts.

---
 rtl/pipe_control_pkg.sv | 27 ++
 rtl/pipe_decode.sv | 70 +++++++
 rtl/pipe_control.sv | 109 ++++++++++
 tb/tb_pipe_control.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pipe_control_pkg.sv
// pipe_control_pkg: shared opcodes, ALU codes, control word and FSM states for the ID stage
package pipe_control_pkg;
  localparam int WORD = 32;
  localparam int ALU_OP_W = 4;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B, OP_TERM = 6'h3F;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_SLLV = 6'h04, FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07, FN_JR = 6'h08, FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A, FN_TERM = 6'h3F;
  localparam logic [3:0] ALU_NO_OP = 4'd0, ALU_ADD = 4'd1, ALU_ADDU = 4'd2, ALU_SUB = 4'd3, ALU_SUBU = 4'd4;
  localparam logic [3:0] ALU_AND = 4'd5, ALU_OR = 4'd6, ALU_XOR = 4'd7, ALU_NOR = 4'd8, ALU_SHL = 4'd9;
  localparam logic [3:0] ALU_SHR = 4'd10, ALU_SHRA = 4'd11, ALU_LE = 4'd12;
  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;
  typedef struct packed {
    logic is_immd;
    logic mem_w;
    logic mem_r;
    logic wb_en;
    logic only_shamt;
    logic is_jal;
    logic is_jr;
    logic [ALU_OP_W-1:0] alu_op;
    logic [4:0] wb_dst;
  } ctrl_t;
endpackage

// File: rtl/pipe_decode.sv
// pipe_decode: combinational op/funct decode into control word, destination and source-use flags
module pipe_decode import pipe_control_pkg::*; (
  input logic [5:0] op,
  input logic [5:0] funct,
  input logic [4:0] rt_idx,
  input logic [4:0] rd_idx,
  output ctrl_t ctrl,
  output logic rs_used,
  output logic rt_used,
  output logic is_beq,
  output logic is_bne,
  output logic is_jump,
  output logic is_term
);
  logic [3:0] r_alu;
  logic is_r, is_shamt;
  always_comb begin
    r_alu = ALU_NO_OP;
    case (funct)
      FN_ADD: r_alu = ALU_ADD;
      FN_ADDU: r_alu = ALU_ADDU;
      FN_SUB: r_alu = ALU_SUB;
      FN_SUBU: r_alu = ALU_SUBU;
      FN_AND: r_alu = ALU_AND;
      FN_OR: r_alu = ALU_OR;
      FN_XOR: r_alu = ALU_XOR;
      FN_NOR: r_alu = ALU_NOR;
      FN_SLT: r_alu = ALU_LE;
      FN_SLL, FN_SLLV: r_alu = ALU_SHL;
      FN_SRL, FN_SRLV: r_alu = ALU_SHR;
      FN_SRA, FN_SRAV: r_alu = ALU_SHRA;
      default: r_alu = ALU_NO_OP;
    endcase
  end
  assign is_r = op == OP_R;
  assign is_shamt = is_r && (funct == FN_SLL || funct == FN_SRL || funct == FN_SRA);
  assign is_beq = op == OP_BEQ;
  assign is_bne = op == OP_BNE;
  assign is_term = op == OP_TERM && funct == FN_TERM;
  assign is_jump = op == OP_J || op == OP_JAL || (is_r && funct == FN_JR);
  assign rs_used = !(is_shamt || op == OP_J || op == OP_JAL);
  assign rt_used = is_r || op == OP_SW || is_beq || is_bne;
  always_comb begin
    ctrl = '0;
    case (op)
      OP_R: begin
        ctrl.alu_op = r_alu;
        ctrl.wb_en = r_alu != ALU_NO_OP;
        ctrl.only_shamt = is_shamt;
        ctrl.is_jr = funct == FN_JR;
        ctrl.wb_dst = r_alu != ALU_NO_OP ? rd_idx : 5'd0;
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW, OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl.is_immd = 1'b1;
        ctrl.mem_r = op == OP_LW;
        ctrl.mem_w = op == OP_SW;
        ctrl.wb_en = op != OP_SW;
        ctrl.alu_op = op == OP_ANDI ? ALU_AND : op == OP_ORI ? ALU_OR : op == OP_XORI ? ALU_XOR : ALU_ADD;
        ctrl.wb_dst = rt_idx;
      end
      OP_JAL: begin
        ctrl.alu_op = ALU_ADD;
        ctrl.is_jal = 1'b1;
        ctrl.wb_en = 1'b1;
        ctrl.wb_dst = 5'd31;
      end
      default: ctrl = '0;
    endcase
  end
endmodule

// File: rtl/pipe_control.sv
// pipe_control: ID/EX control register, hazard stalls, branch resolve, drain/halt FSM; PIPE_CONTROL_PERF_EN adds counters
module pipe_control #(
  parameter int WORD = 32,
  parameter int ALU_OP_W = 4,
  parameter int DRAIN_DEPTH = 4,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  input logic [5:0] op,
  input logic [5:0] funct,
  input logic [4:0] rs_idx,
  input logic [4:0] rt_idx,
  input logic [4:0] rd_idx,
  input logic [WORD-1:0] reg_rs_d,
  input logic [WORD-1:0] reg_rt_d,
  output logic ex_is_immd,
  output logic ex_mem_w,
  output logic ex_mem_r,
  output logic ex_wb_en,
  output logic ex_only_shamt,
  output logic ex_is_jal,
  output logic ex_is_jr,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic [4:0] ex_wb_dst,
  output logic branch_taken,
  output logic jump_taken,
  output logic is_branch,
  output logic stall,
  output logic flush,
  output logic halted
`ifdef PIPE_CONTROL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);
  import pipe_control_pkg::*;
  ctrl_t dec, ex_q;
  state_t state;
  logic [1:0] scnt;
  logic [3:0] dcnt;
  logic rs_used, rt_used, is_beq, is_bne, is_jmp, is_term, run, br_use, match, hz;
  pipe_decode u_dec (
    .op(op),
    .funct(funct),
    .rt_idx(rt_idx),
    .rd_idx(rd_idx),
    .ctrl(dec),
    .rs_used(rs_used),
    .rt_used(rt_used),
    .is_beq(is_beq),
    .is_bne(is_bne),
    .is_jump(is_jmp),
    .is_term(is_term)
  );
  assign {ex_is_immd, ex_mem_w, ex_mem_r, ex_wb_en} = {ex_q.is_immd, ex_q.mem_w, ex_q.mem_r, ex_q.wb_en};
  assign {ex_only_shamt, ex_is_jal, ex_is_jr} = {ex_q.only_shamt, ex_q.is_jal, ex_q.is_jr};
  assign ex_alu_op = ALU_OP_W'(ex_q.alu_op);
  assign ex_wb_dst = ex_q.wb_dst;
  assign run = state == RUN;
  assign br_use = is_beq || is_bne || dec.is_jr;
  assign match = ex_q.wb_en && ex_q.wb_dst != 5'd0 &&
                 ((rs_used && ex_q.wb_dst == rs_idx) || (rt_used && ex_q.wb_dst == rt_idx));
  assign hz = run && scnt == 2'd0 && match && (ex_q.mem_r || br_use);
  assign stall = !run || scnt != 2'd0 || hz;
  assign is_branch = is_beq || is_bne;
  assign branch_taken = !stall && ((is_beq && reg_rs_d == reg_rt_d) || (is_bne && reg_rs_d != reg_rt_d));
  assign jump_taken = !stall && is_jmp;
  assign flush = branch_taken || jump_taken;
  // scnt holds stall cycles still owed after the current one; a load feeding a branch owes one more
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q <= '0;
      state <= RUN;
      scnt <= 2'd0;
      dcnt <= 4'd0;
      halted <= 1'b0;
    end else begin
      ex_q <= stall ? '0 : dec;
      scnt <= scnt != 2'd0 ? scnt - 2'd1 : (hz && ex_q.mem_r && br_use) ? 2'd1 : 2'd0;
      case (state)
        RUN: if (is_term && !stall) begin
          state <= DRAIN;
          dcnt <= 4'(DRAIN_DEPTH - 1);
        end
        DRAIN: if (dcnt == 4'd0) begin
          state <= HALT;
          halted <= 1'b1;
        end else dcnt <= dcnt - 4'd1;
        default: halted <= 1'b1;
      endcase
    end
  end
`ifdef PIPE_CONTROL_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count <= '0;
    end else begin
      if (run && stall && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
      if (flush && !(&flush_count)) flush_count <= flush_count + 1'b1;
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = CNT_W > 0;
`endif
endmodule

// File: tb/tb_pipe_control.sv
// tb_pipe_control: scoreboard bench for pipe_control decode, hazards, branches and drain/halt
module tb_pipe_control;
  localparam int S_ALU = 0, S_WB = 1, S_DST = 2, S_STALL = 3, S_BT = 4, S_FL = 5, S_HALT = 6, S_MR = 7;
  localparam int S_JT = 8, S_JAL = 9, S_SC = 10, S_FC = 11, S_IMM = 12, S_MW = 13, S_BR = 14, S_SH = 15, S_JR = 16;
  logic clk = 0, rst_n = 0;
  logic [5:0] op, funct;
  logic [4:0] rs_idx, rt_idx, rd_idx;
  logic [31:0] reg_rs_d, reg_rt_d;
  logic ex_is_immd, ex_mem_w, ex_mem_r, ex_wb_en, ex_only_shamt, ex_is_jal, ex_is_jr;
  logic [3:0] ex_alu_op;
  logic [4:0] ex_wb_dst;
  logic branch_taken, jump_taken, is_branch, stall, flush, halted;
`ifdef PIPE_CONTROL_PERF_EN
  logic [1:0] stall_cycles, flush_count;
`endif
  pipe_control #(.CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .rs_idx(rs_idx), .rt_idx(rt_idx), .rd_idx(rd_idx),
    .reg_rs_d(reg_rs_d), .reg_rt_d(reg_rt_d), .ex_is_immd(ex_is_immd), .ex_mem_w(ex_mem_w),
    .ex_mem_r(ex_mem_r), .ex_wb_en(ex_wb_en), .ex_only_shamt(ex_only_shamt), .ex_is_jal(ex_is_jal),
    .ex_is_jr(ex_is_jr), .ex_alu_op(ex_alu_op), .ex_wb_dst(ex_wb_dst), .branch_taken(branch_taken),
    .jump_taken(jump_taken), .is_branch(is_branch), .stall(stall), .flush(flush), .halted(halted)
`ifdef PIPE_CONTROL_PERF_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    int c;
    int s;
    logic [31:0] v;
    string n;
  } exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  function automatic logic [31:0] peek(int s);
    case (s)
      S_ALU: return 32'(ex_alu_op);
      S_WB: return 32'(ex_wb_en);
      S_DST: return 32'(ex_wb_dst);
      S_STALL: return 32'(stall);
      S_BT: return 32'(branch_taken);
      S_FL: return 32'(flush);
      S_HALT: return 32'(halted);
      S_MR: return 32'(ex_mem_r);
      S_JT: return 32'(jump_taken);
      S_JAL: return 32'(ex_is_jal);
      S_IMM: return 32'(ex_is_immd);
      S_MW: return 32'(ex_mem_w);
      S_BR: return 32'(is_branch);
      S_SH: return 32'(ex_only_shamt);
      S_JR: return 32'(ex_is_jr);
`ifdef PIPE_CONTROL_PERF_EN
      S_SC: return 32'(stall_cycles);
      S_FC: return 32'(flush_count);
`endif
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction
  always @(negedge clk)
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].c <= cyc) begin
        n_chk++;
        if (q[i].c < cyc || peek(q[i].s) !== q[i].v) begin
          n_fail++;
          $display("FAIL %s @cycle %0d: got %0h want %0h", q[i].n, cyc, peek(q[i].s), q[i].v);
        end
        q.delete(i);
      end
  task automatic ex(int d, int s, logic [31:0] v, string n);
    exp_t e;
    e.c = cyc + d;
    e.s = s;
    e.v = v;
    e.n = n;
    q.push_back(e);
  endtask
  task automatic drv(logic [5:0] o, logic [5:0] f, logic [4:0] s, logic [4:0] t, logic [4:0] d,
                     logic [31:0] a = 0, logic [31:0] b = 0);
    @(posedge clk);
    #1;
    op = o; funct = f; rs_idx = s; rt_idx = t; rd_idx = d; reg_rs_d = a; reg_rt_d = b;
  endtask
  task automatic idle();
    drv(6'h3E, 6'h00, 5'd0, 5'd0, 5'd0);
  endtask
  initial begin
    op = 6'h3E; funct = 0; rs_idx = 0; rt_idx = 0; rd_idx = 0; reg_rs_d = 0; reg_rt_d = 0;
    repeat (3) idle();
    ex(0, S_WB, 0, "rst_wb_en"); ex(0, S_ALU, 0, "rst_alu"); ex(0, S_DST, 0, "rst_dst");
    ex(0, S_MR, 0, "rst_mem_r"); ex(0, S_HALT, 0, "rst_halted"); ex(0, S_STALL, 0, "rst_stall");
    rst_n = 1;
    drv(6'h00, 6'h20, 1, 2, 3);
    ex(0, S_STALL, 0, "add_stall"); ex(1, S_ALU, 1, "add_alu"); ex(1, S_WB, 1, "add_wb"); ex(1, S_DST, 3, "add_dst");
    drv(6'h00, 6'h23, 1, 2, 10); ex(1, S_ALU, 4, "subu_alu");
    drv(6'h00, 6'h2A, 1, 2, 11); ex(1, S_ALU, 12, "slt_le");
    drv(6'h00, 6'h03, 1, 2, 12); ex(1, S_ALU, 11, "sra_alu"); ex(1, S_SH, 1, "sra_shamt");
    drv(6'h0E, 6'h00, 1, 13, 0);
    ex(1, S_ALU, 7, "xori_alu"); ex(1, S_IMM, 1, "xori_imm"); ex(1, S_DST, 13, "xori_dst");
    drv(6'h2B, 6'h00, 1, 2, 0); ex(1, S_MW, 1, "sw_mem_w"); ex(1, S_WB, 0, "sw_wb");
    drv(6'h00, 6'h3D, 1, 2, 7); ex(1, S_WB, 0, "bad_funct_wb"); ex(1, S_ALU, 0, "bad_funct_alu");
    idle();
    drv(6'h23, 6'h00, 1, 5, 0);
    ex(0, S_STALL, 0, "lw_stall"); ex(1, S_MR, 1, "lw_mem_r"); ex(1, S_DST, 5, "lw_dst");
    drv(6'h00, 6'h20, 5, 2, 6);
    ex(0, S_STALL, 1, "lu_stall"); ex(1, S_WB, 0, "lu_bubble"); ex(1, S_ALU, 0, "lu_bubble_alu");
    drv(6'h00, 6'h20, 5, 2, 6);
    ex(0, S_STALL, 0, "lu_release"); ex(1, S_ALU, 1, "lu_add_alu"); ex(1, S_DST, 6, "lu_add_dst");
    idle();
    drv(6'h23, 6'h00, 1, 5, 0);
    drv(6'h04, 6'h00, 5, 2, 0, 9, 9);
    ex(0, S_STALL, 1, "lb_stall1"); ex(0, S_BT, 0, "lb_bt1"); ex(0, S_BR, 1, "lb_isbr");
    drv(6'h04, 6'h00, 5, 2, 0, 9, 9); ex(0, S_STALL, 1, "lb_stall2"); ex(0, S_FL, 0, "lb_fl2");
    drv(6'h04, 6'h00, 5, 2, 0, 9, 9);
    ex(0, S_STALL, 0, "lb_release"); ex(0, S_BT, 1, "lb_bt"); ex(0, S_FL, 1, "lb_flush");
    drv(6'h08, 6'h00, 1, 0, 0);
    ex(1, S_WB, 1, "addi_wb"); ex(1, S_IMM, 1, "addi_imm"); ex(1, S_DST, 0, "addi_dst0");
    drv(6'h04, 6'h00, 0, 0, 0, 1, 2); ex(0, S_STALL, 0, "dst0_nostall"); ex(0, S_BT, 0, "beq_ne");
    drv(6'h05, 6'h00, 1, 2, 0, 7, 7); ex(0, S_BT, 0, "bne_eq"); ex(0, S_FL, 0, "bne_eq_fl");
    drv(6'h05, 6'h00, 1, 2, 0, 7, 8); ex(0, S_BT, 1, "bne_ne");
    drv(6'h03, 6'h00, 0, 0, 0);
    ex(0, S_JT, 1, "jal_jt"); ex(0, S_FL, 1, "jal_fl"); ex(1, S_JAL, 1, "jal_ex");
    ex(1, S_DST, 31, "jal_dst"); ex(1, S_ALU, 1, "jal_alu");
    drv(6'h00, 6'h08, 31, 0, 0); ex(0, S_STALL, 1, "jr_alu_haz"); ex(0, S_JT, 0, "jr_jt_held");
    drv(6'h00, 6'h08, 31, 0, 0);
    ex(0, S_STALL, 0, "jr_release"); ex(0, S_JT, 1, "jr_jt"); ex(1, S_JR, 1, "jr_ex"); ex(1, S_ALU, 0, "jr_noop");
    drv(6'h02, 6'h00, 0, 0, 0); ex(0, S_JT, 1, "j_jt"); ex(1, S_WB, 0, "j_wb");
    drv(6'h23, 6'h00, 1, 5, 0);
    drv(6'h3F, 6'h3F, 5, 0, 0); ex(0, S_STALL, 1, "term_haz");
    drv(6'h3F, 6'h3F, 5, 0, 0); ex(0, S_STALL, 0, "term_go");
    for (int i = 1; i <= 4; i++) begin
      ex(i, S_STALL, 1, "drain_stall"); ex(i, S_HALT, 0, "drain_halt");
    end
    ex(5, S_HALT, 1, "halted"); ex(7, S_HALT, 1, "halt_hold"); ex(7, S_STALL, 1, "halt_stall");
    drv(6'h00, 6'h20, 1, 2, 3); ex(1, S_WB, 0, "drain_bubble");
    repeat (6) drv(6'h00, 6'h20, 1, 2, 3);
    ex(0, S_WB, 0, "halt_bubble");
    rst_n = 0;
    idle(); ex(0, S_HALT, 0, "rst_halt"); ex(0, S_STALL, 0, "rst_run");
    rst_n = 1;
    drv(6'h00, 6'h20, 1, 2, 3); ex(1, S_WB, 1, "post_rst_add");
`ifdef PIPE_CONTROL_PERF_EN
    idle();
    rst_n = 0;
    idle(); ex(0, S_SC, 0, "sc_rst"); ex(0, S_FC, 0, "fc_rst");
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      drv(6'h23, 6'h00, 1, 5, 0);
      drv(6'h00, 6'h20, 5, 2, 6);
      drv(6'h00, 6'h20, 5, 2, 6);
    end
    idle(); ex(0, S_SC, 3, "sc_sat"); ex(0, S_FC, 0, "fc_zero");
    drv(6'h02, 6'h00, 0, 0, 0);
    drv(6'h02, 6'h00, 0, 0, 0);
    idle(); ex(0, S_FC, 2, "fc_two"); ex(0, S_SC, 3, "sc_hold");
`endif
    repeat (3) idle();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
